// File: rtl/ae_pkg.sv
// Shared definitions for the arithmetic-encoder output path: FSM states,
// default widths and the all-ones byte value.
package ae_pkg;

    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned DEF_RUN_W  = 16;

    localparam logic [DEF_BYTE_W-1:0] BYTE_FF = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_PEND,
        EMIT_RUN,
        DONE,
        FLUSH
    } state_e;

endpackage

// File: rtl/ae_out_reg.sv
// Output holding register with valid/ready handshake. Carries the resolved
// byte and its end-of-frame marker; holds everything stable while stalled.
module ae_out_reg #(
    parameter int unsigned BYTE_W = 8
) (
    input  logic              general_clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_byte,
    input  logic              push_last,
    output logic              load_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last
);

    // Register may be (re)loaded when empty or when its byte is being taken.
    assign load_ready = !out_valid || out_ready;

    // Load a new byte, or empty the register once its byte is consumed.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
        end else if (load_ready) begin
            out_valid <= push;
            if (push) begin
                out_byte <= push_byte;
                out_last <= push_last;
            end
        end
    end

endmodule

// File: rtl/carry_resolver.sv
// Carry resolver: holds the latest non-final byte and a run of pending 0xFF
// bytes until an incoming carry resolves them, then streams resolved bytes.
// Optional feature macro: CARRY_STATS_EN adds stat_bytes/stat_carries.
module carry_resolver
    import ae_pkg::*;
#(
    parameter int unsigned BYTE_W = DEF_BYTE_W,
    parameter int unsigned RUN_W  = DEF_RUN_W
) (
    input  logic              general_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W:0]   in_byte,
    input  logic              in_flush,
    input  logic              in_byte_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
`ifdef CARRY_STATS_EN
    output logic [31:0]       stat_bytes,
    output logic [31:0]       stat_carries,
`endif
    output logic              err
);

    localparam logic [BYTE_W-1:0] BYTE_ONES = '1;
    localparam logic [BYTE_W-1:0] BYTE_ONE  = {{(BYTE_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0]  RUN_ONES  = '1;
    localparam logic [RUN_W-1:0]  RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [BYTE_W-1:0] pend_q;
    logic [BYTE_W-1:0] nxt_q;
    logic              pend_vld_q;
    logic              rc_q;
    logic              flush_q;
    logic [RUN_W-1:0]  run_q;
    logic              err_q;

    logic              push;
    logic [BYTE_W-1:0] push_byte;
    logic              push_last;
    logic              load_ready;

    logic              in_c;
    logic [BYTE_W-1:0] in_b;

    assign in_c     = in_byte[BYTE_W];
    assign in_b     = in_byte[BYTE_W-1:0];
    assign in_ready = (state_q == IDLE);
    assign err      = err_q;

    // Byte offered to the output register in each emitting state.
    always_comb begin
        push      = 1'b0;
        push_byte = '0;
        push_last = 1'b0;
        unique case (state_q)
            EMIT_PEND: begin
                push      = 1'b1;
                push_byte = rc_q ? pend_q + BYTE_ONE : pend_q;
            end
            EMIT_RUN: begin
                push      = 1'b1;
                push_byte = rc_q ? '0 : BYTE_ONES;
            end
            FLUSH: begin
                push = 1'b1;
                if (pend_vld_q) begin
                    push_byte = rc_q ? pend_q + BYTE_ONE : pend_q;
                    push_last = (run_q == '0);
                end else begin
                    push_byte = rc_q ? '0 : BYTE_ONES;
                    push_last = (run_q == RUN_ONE);
                end
            end
            default: ;
        endcase
    end

    // Accept precarry bytes, track pending byte/run and sequence the emission.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            nxt_q      <= '0;
            pend_vld_q <= 1'b0;
            rc_q       <= 1'b0;
            flush_q    <= 1'b0;
            run_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_byte_en) begin
                        if (!pend_vld_q) begin
                            // Carry into nothing already emitted is an error.
                            pend_q     <= in_b;
                            pend_vld_q <= 1'b1;
                            if (in_c) err_q <= 1'b1;
                            if (in_flush) state_q <= FLUSH;
                        end else if (!in_c && in_b == BYTE_ONES) begin
                            if (run_q == RUN_ONES) err_q <= 1'b1;
                            else                   run_q <= run_q + RUN_ONE;
                            if (in_flush) state_q <= FLUSH;
                        end else begin
                            rc_q    <= in_c;
                            nxt_q   <= in_b;
                            flush_q <= in_flush;
                            state_q <= EMIT_PEND;
                        end
                    end else if (in_valid && in_flush && pend_vld_q) begin
                        state_q <= FLUSH;
                    end
                end
                EMIT_PEND: begin
                    if (load_ready) begin
                        if (rc_q && pend_q == BYTE_ONES) err_q <= 1'b1;
                        state_q <= (run_q != '0) ? EMIT_RUN : DONE;
                    end
                end
                EMIT_RUN: begin
                    if (load_ready) begin
                        run_q <= run_q - RUN_ONE;
                        if (run_q == RUN_ONE) state_q <= DONE;
                    end
                end
                DONE: begin
                    // The new byte becomes pending; its own carry is not yet known.
                    pend_q  <= nxt_q;
                    rc_q    <= 1'b0;
                    flush_q <= 1'b0;
                    state_q <= flush_q ? FLUSH : IDLE;
                end
                FLUSH: begin
                    if (load_ready) begin
                        if (push_last) begin
                            pend_vld_q <= 1'b0;
                            run_q      <= '0;
                            rc_q       <= 1'b0;
                            state_q    <= IDLE;
                        end else if (pend_vld_q) begin
                            pend_vld_q <= 1'b0;
                        end else begin
                            run_q <= run_q - RUN_ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ae_out_reg #(
        .BYTE_W(BYTE_W)
    ) u_out_reg (
        .general_clk(general_clk),
        .reset      (reset),
        .push       (push),
        .push_byte  (push_byte),
        .push_last  (push_last),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last)
    );

`ifdef CARRY_STATS_EN
    logic [31:0] stat_bytes_q;
    logic [31:0] stat_carries_q;

    // Count handshaken output bytes and resolutions that carried.
    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            stat_bytes_q   <= '0;
            stat_carries_q <= '0;
        end else begin
            if (out_valid && out_ready) stat_bytes_q <= stat_bytes_q + 32'd1;
            if (state_q == EMIT_PEND && load_ready && rc_q) begin
                stat_carries_q <= stat_carries_q + 32'd1;
            end
        end
    end

    assign stat_bytes   = stat_bytes_q;
    assign stat_carries = stat_carries_q;
`endif

endmodule

// File: tb/tb_carry_resolver.sv
// Directed self-checking bench for carry_resolver.
module tb_carry_resolver;

    logic       general_clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_byte;
    logic       in_flush;
    logic       in_byte_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       err;
`ifdef CARRY_STATS_EN
    logic [31:0] stat_bytes;
    logic [31:0] stat_carries;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] cap_byte[$];
    logic       cap_last[$];

    carry_resolver dut (
        .general_clk(general_clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .in_flush   (in_flush),
        .in_byte_en (in_byte_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
`ifdef CARRY_STATS_EN
        .stat_bytes  (stat_bytes),
        .stat_carries(stat_carries),
`endif
        .err        (err)
    );

    initial general_clk = 1'b0;
    always #5 general_clk = ~general_clk;

    // Record every byte that will be handshaken at the next rising edge.
    always @(negedge general_clk) begin
        if (reset && out_valid && out_ready) begin
            cap_byte.push_back(out_byte);
            cap_last.push_back(out_last);
        end
    end

    // One transfer; called and returns just after a rising edge.
    task automatic send(input logic [8:0] b, input logic en, input logic fl);
        int n = 0;
        in_valid   = 1'b1;
        in_byte    = b;
        in_byte_en = en;
        in_flush   = fl;
        @(negedge general_clk);
        while (!in_ready && n < 200) begin
            @(negedge general_clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: in_ready stuck low for byte %h", b);
        end
        @(posedge general_clk);
        #1;
        in_valid   = 1'b0;
        in_byte    = '0;
        in_byte_en = 1'b0;
        in_flush   = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge general_clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge general_clk);
        @(negedge general_clk);
        reset = 1'b1;
        @(posedge general_clk);
        #1;
        n_checks++;
        if ({out_valid, out_byte, out_last, err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL reset_values: got v=%b b=%h l=%b e=%b r=%b want v=0 b=00 l=0 e=0 r=1",
                     out_valid, out_byte, out_last, err, in_ready);
        end
    endtask

    task automatic test_plain;
        logic [7:0] eb[$] = '{8'h12, 8'h34, 8'h56};
        logic       el[$] = '{1'b0, 1'b0, 1'b1};
        cap_byte.delete();
        cap_last.delete();
        send(9'h012, 1'b1, 1'b0);
        send(9'h034, 1'b1, 1'b0);
        send(9'h056, 1'b1, 1'b0);
        send(9'h000, 1'b0, 1'b1);
        drain(20);
        n_checks++;
        if (cap_byte.size() != eb.size()) begin
            n_fails++;
            $display("FAIL plain_count: got %0d want %0d", cap_byte.size(), eb.size());
        end
        for (int i = 0; i < eb.size() && i < cap_byte.size(); i++) begin
            n_checks++;
            if (cap_byte[i] !== eb[i] || cap_last[i] !== el[i]) begin
                n_fails++;
                $display("FAIL plain_out%0d: got %h/%b want %h/%b", i, cap_byte[i], cap_last[i],
                         eb[i], el[i]);
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fails++;
            $display("FAIL plain_err: got %b want 0", err);
        end
    endtask

    task automatic test_empty_flush;
        cap_byte.delete();
        cap_last.delete();
        send(9'h000, 1'b0, 1'b1);
        drain(5);
        n_checks++;
        if (cap_byte.size() != 0 || in_ready !== 1'b1 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL empty_flush: got n=%0d r=%b e=%b want n=0 r=1 e=0",
                     cap_byte.size(), in_ready, err);
        end
    endtask

    task automatic test_carry_run;
        logic [7:0] eb[$] = '{8'h13, 8'h00, 8'h00, 8'h00};
        logic       el[$] = '{1'b0, 1'b0, 1'b0, 1'b1};
        cap_byte.delete();
        cap_last.delete();
        send(9'h012, 1'b1, 1'b0);
        send(9'h0FF, 1'b1, 1'b0);
        send(9'h0FF, 1'b1, 1'b0);
        send(9'h100, 1'b1, 1'b0);
        send(9'h000, 1'b0, 1'b1);
        drain(20);
        n_checks++;
        if (cap_byte.size() != eb.size()) begin
            n_fails++;
            $display("FAIL carry_count: got %0d want %0d", cap_byte.size(), eb.size());
        end
        for (int i = 0; i < eb.size() && i < cap_byte.size(); i++) begin
            n_checks++;
            if (cap_byte[i] !== eb[i] || cap_last[i] !== el[i]) begin
                n_fails++;
                $display("FAIL carry_out%0d: got %h/%b want %h/%b", i, cap_byte[i], cap_last[i],
                         eb[i], el[i]);
            end
        end
    endtask

    task automatic test_flush_same;
        logic [7:0] eb[$] = '{8'h12, 8'hFF, 8'hFF, 8'h45};
        logic       el[$] = '{1'b0, 1'b0, 1'b0, 1'b1};
        cap_byte.delete();
        cap_last.delete();
        send(9'h012, 1'b1, 1'b0);
        send(9'h0FF, 1'b1, 1'b0);
        send(9'h0FF, 1'b1, 1'b0);
        send(9'h045, 1'b1, 1'b1);
        drain(20);
        n_checks++;
        if (cap_byte.size() != eb.size()) begin
            n_fails++;
            $display("FAIL same_count: got %0d want %0d", cap_byte.size(), eb.size());
        end
        for (int i = 0; i < eb.size() && i < cap_byte.size(); i++) begin
            n_checks++;
            if (cap_byte[i] !== eb[i] || cap_last[i] !== el[i]) begin
                n_fails++;
                $display("FAIL same_out%0d: got %h/%b want %h/%b", i, cap_byte[i], cap_last[i],
                         eb[i], el[i]);
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] eb[$] = '{8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h34};
        logic       el[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cap_byte.delete();
        cap_last.delete();
        send(9'h012, 1'b1, 1'b0);
        repeat (4) send(9'h0FF, 1'b1, 1'b0);
        send(9'h034, 1'b1, 1'b0);
        drain(2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge general_clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_byte !== 8'hFF || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL stall_hold%0d: got v=%b b=%h r=%b want v=1 b=ff r=0",
                         i, out_valid, out_byte, in_ready);
            end
        end
        @(posedge general_clk);
        #1;
        out_ready = 1'b1;
        drain(20);
        send(9'h000, 1'b0, 1'b1);
        drain(10);
        n_checks++;
        if (cap_byte.size() != eb.size()) begin
            n_fails++;
            $display("FAIL stall_count: got %0d want %0d", cap_byte.size(), eb.size());
        end
        for (int i = 0; i < eb.size() && i < cap_byte.size(); i++) begin
            n_checks++;
            if (cap_byte[i] !== eb[i] || cap_last[i] !== el[i]) begin
                n_fails++;
                $display("FAIL stall_out%0d: got %h/%b want %h/%b", i, cap_byte[i], cap_last[i],
                         eb[i], el[i]);
            end
        end
    endtask

    task automatic test_err_first;
        cap_byte.delete();
        cap_last.delete();
        send(9'h1AB, 1'b1, 1'b0);
        drain(2);
        n_checks++;
        if (err !== 1'b1 || cap_byte.size() != 0) begin
            n_fails++;
            $display("FAIL err_set: got e=%b n=%0d want e=1 n=0", err, cap_byte.size());
        end
        send(9'h000, 1'b0, 1'b1);
        drain(10);
        n_checks++;
        if (cap_byte.size() != 1) begin
            n_fails++;
            $display("FAIL err_count: got %0d want 1", cap_byte.size());
        end else begin
            n_checks++;
            if (cap_byte[0] !== 8'hAB || cap_last[0] !== 1'b1) begin
                n_fails++;
                $display("FAIL err_out: got %h/%b want ab/1", cap_byte[0], cap_last[0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        send(9'h012, 1'b1, 1'b0);
        repeat (3) send(9'h0FF, 1'b1, 1'b0);
        send(9'h034, 1'b1, 1'b0);
        drain(1);
        n_checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h12) begin
            n_fails++;
            $display("FAIL mid_pre: got v=%b b=%h want v=1 b=12", out_valid, out_byte);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_reset: got v=%b e=%b r=%b want v=0 e=0 r=1",
                     out_valid, err, in_ready);
        end
        repeat (2) @(posedge general_clk);
        @(negedge general_clk);
        reset = 1'b1;
        @(posedge general_clk);
        #1;
        cap_byte.delete();
        cap_last.delete();
        send(9'h022, 1'b1, 1'b0);
        send(9'h000, 1'b0, 1'b1);
        drain(10);
        n_checks++;
        if (cap_byte.size() != 1) begin
            n_fails++;
            $display("FAIL mid_count: got %0d want 1", cap_byte.size());
        end else begin
            n_checks++;
            if (cap_byte[0] !== 8'h22 || cap_last[0] !== 1'b1) begin
                n_fails++;
                $display("FAIL mid_out: got %h/%b want 22/1", cap_byte[0], cap_last[0]);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_byte    = '0;
        in_flush   = 1'b0;
        in_byte_en = 1'b0;
        out_ready  = 1'b1;
        test_reset();
        test_plain();
        test_empty_flush();
        test_carry_run();
        test_flush_same();
        test_stall();
        test_err_first();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/carry_resolver.md
# carry_resolver

Carry-propagation and byte-output stage placed directly downstream of the arithmetic encoder normalization path. It accepts 9-bit precarry bytes: bit 8 is a carry into already-produced output, bits 7:0 are the byte. It holds the most recent non-final byte plus a run of pending 0xFF bytes until their carry is known, then emits resolved 8-bit bitstream bytes one per cycle under a valid/ready handshake. A flush closes the frame and marks the last byte.

## Interface
- BYTE_W, 8, output byte width; precarry input is BYTE_W+1 bits.
- RUN_W, 16, width of the pending-0xFF run counter.
- general_clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  precarry byte and/or flush present.
- in_ready  out  1  block can accept; combinational, high only in IDLE.
- in_byte  in  BYTE_W+1  precarry byte; [BYTE_W] is carry, [BYTE_W-1:0] is data.
- in_flush  in  1  end of frame; qualified by in_valid; with in_byte_en=0 it is a flush only.
- in_byte_en  in  1  in_byte is meaningful in this transfer.
- out_valid  out  1  registered; out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- out_byte  out  BYTE_W  resolved bitstream byte.
- out_last  out  1  final byte of the frame.
- err  out  1  sticky; set on carry with nothing pending or on run-counter overflow.

## Operation
- Reset values: out_valid=0, out_byte=0, out_last=0, err=0, state=IDLE, pend_vld=0, run=0. in_ready=1 after reset.
- Transfer occurs when in_valid & in_ready. The carry c is in_byte[8] and the data b is in_byte[7:0].
- Accept rules with in_byte_en=1:
  - If pend_vld=0: pend=b, pend_vld=1. If c=1, set err and drop the carry.
  - Else if c=0 and b=0xFF: run+=1 and stay in IDLE. If run is already at all-ones, set err and leave run saturated.
  - Else: latch c as rc and new byte b as nxt, then go to EMIT_PEND.
- States:
  - EMIT_PEND: drive pend+rc, mod 2^BYTE_W. If pend=0xFF and rc=1, set err. Go to EMIT_RUN if run>0, else DONE.
  - EMIT_RUN: drive (rc ? 0x00 : 0xFF) and decrement run. Leave when run reaches 0.
  - DONE: pend=nxt, return to IDLE.
  - FLUSH: reached on accepted in_flush, after the flush transfer's own byte (if any) is processed by the rules above with that byte's carry. Emits pend, then run bytes of 0xFF, all with rc applied. out_last=1 on the final emitted byte. Then pend_vld=0, run=0, IDLE.
- Flush with nothing pending: no output and an immediate return to IDLE. err is not affected.
- out_byte advances only when out_valid & out_ready, or when out_valid=0. out_byte, out_valid and out_last hold stable while stalled.
- err is cleared only by reset.

## Timing
- Output register: one byte per cycle at full throughput.
- Resolution cost: a non-0xFF byte costs 1+run output cycles plus 1 DONE cycle, during which in_ready=0.
- First-byte latency: the first output of a resolution appears on the cycle after acceptance.
- 0xFF bytes that extend a run, and bytes accepted with nothing pending, are absorbed with no output.
- Simultaneous in_byte_en and in_flush: the byte is processed first, then the flush drains, in a single transfer.
- Mid-operation reset: asynchronously drops out_valid and discards pend, run and nxt. No partial frame is resumed.

## Configuration
- CARRY_STATS_EN defined: adds outputs stat_bytes[31:0] and stat_carries[31:0].
  - stat_bytes counts handshaken out bytes.
  - stat_carries counts resolutions with rc=1.
  - Both reset to 0 and wrap mod 2^32.
- CARRY_STATS_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package ae_pkg holds:
  - state enum {IDLE, EMIT_PEND, EMIT_RUN, DONE, FLUSH};
  - BYTE_FF constant;
  - default BYTE_W/RUN_W localparams.
- One sub-module, ae_out_reg: output valid/ready holding register carrying out_byte and out_last.

## Test plan
- In 0x012, 0x034, 0x056, then flush → out 0x12, 0x34, 0x56, with out_last on 0x56 and err=0.
- In 0x012, 0x0FF, 0x0FF, 0x100, then flush → out 0x13, 0x00, 0x00, 0x00, with out_last on the last 0x00.
- In 0x012, 0x0FF, 0x0FF, 0x045, then flush (flush in the same transfer as 0x045) → out 0x12, 0xFF, 0xFF, 0x45 with last.
- First byte 0x1AB → err=1, pend=0xAB. Then flush → single out 0xAB with last.
- Hold out_ready=0 for 5 cycles during EMIT_RUN → out_byte stable, in_ready=0, and no bytes lost or duplicated.
- Assert reset in EMIT_RUN with run=3 → out_valid=0 immediately. After release, 0x022 then flush → out 0x22 with last.
